fallthrough_pkt_fifo: RTL and testbench
=======================================

# fallthrough_pkt_fifo

Single-clock, first-word-fall-through FIFO, parametrised in width, depth and threshold levels. It adds an occupancy count and packet-boundary tracking via an end-of-packet sideband bit. It is the general-purpose buffering element for the datapath: output queues, input arbiters and header parsers use it where a consumer must see a whole packet before it starts reading.

## Interface
- `WIDTH`, 72: data width in bits, excluding the EOP sideband bit.
- `MAX_DEPTH_BITS`, 3: depth is 2**MAX_DEPTH_BITS words; legal range 1..10.
- `NEARLY_FULL_THRESH`, 2**MAX_DEPTH_BITS-1: `nearly_full` is high when occupancy >= this value.
- `NEARLY_EMPTY_THRESH`, 1: `nearly_empty` is high when occupancy <= this value.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  write data.
- `din_eop`  in  1  marks `din` as the last word of a packet.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  pop the head word.
- `dout`  out  WIDTH  head word; valid whenever `empty`=0.
- `dout_eop`  out  1  EOP bit of the head word.
- `full`, `nearly_full`, `empty`, `nearly_empty`  out  1 each  status flags.
- `data_count`  out  MAX_DEPTH_BITS+1  current occupancy in words.
- `pkt_count`  out  MAX_DEPTH_BITS+1  number of complete packets stored.
- `pkt_avail`  out  1  high when `pkt_count` != 0.
- `overflow`, `underflow`  out  1 each  sticky error flags; present only with the macro below.

## Operation
- Storage: circular array of 2**MAX_DEPTH_BITS entries of WIDTH+1 bits. Write and read pointers are MAX_DEPTH_BITS wide and wrap naturally from 2**MAX_DEPTH_BITS-1 to 0.
- Write acceptance: `wr_acc` = `wr_en` & (~`full` | `rd_en`). A write into a full FIFO succeeds if it coincides with a read.
- Read acceptance: `rd_acc` = `rd_en` & ~`empty`. A read on an empty FIFO is ignored, even when `wr_en` is high in the same cycle.
- `data_count` changes by +1 when only `wr_acc` fires, by -1 when only `rd_acc` fires, and is unchanged when both or neither fire.
- Flags are combinational decodes of the registered `data_count`:
  - `empty` = (count==0).
  - `full` = (count==2**MAX_DEPTH_BITS).
  - `nearly_full` = (count>=NEARLY_FULL_THRESH).
  - `nearly_empty` = (count<=NEARLY_EMPTY_THRESH).
- `pkt_count` changes by +1 on `wr_acc`&`din_eop`, by -1 on `rd_acc`&`dout_eop`, and is unchanged when both fire. It never exceeds `data_count`.
- `dout`/`dout_eop` are read combinationally from the head entry at the read pointer.
- Reset (asynchronous; takes effect mid-transfer as well): pointers, `data_count` and `pkt_count` go to 0, and sticky flags clear.
  - Output values in reset: `empty`=1, `nearly_empty`=1, `full`=0, `nearly_full`=0, `pkt_avail`=0.
  - `nearly_full`=0 requires NEARLY_FULL_THRESH >= 1.
  - Storage contents are not cleared; `dout` is don't-care while `empty`=1.

## Timing
- Write-to-read latency is 1 cycle: a word written at edge k appears on `dout` with `empty`=0 immediately after edge k.
- Pop: with `rd_en` high at edge k, the next word (or `empty`=1) is presented after edge k.
- Full throughput: one write and one read per cycle are sustained indefinitely at any occupancy from 1 to full.
- All outputs change only on `clk` edges or on `reset` assertion; there are no combinational paths from inputs to outputs.
- `reset` deassertion must be synchronous to `clk` (the system reset synchroniser provides this).

## Configuration
- `FALLTHROUGH_PKT_FIFO_ERR_CHK_EN`
- Defined:
  - `overflow` sets on `wr_en` & `full` & ~`rd_en`.
  - `underflow` sets on `rd_en` & `empty`.
  - Both are sticky until `reset`.
  - A simulation-only `$display` reports each event with the time of occurrence.
- Undefined: the ports and logic are removed; illegal requests are silently dropped, exactly as described in Operation.

## Test plan
- Reset, then 8 writes (MAX_DEPTH_BITS=3) of 0x1..0x8 with no reads:
  - After write 7: `nearly_full`=1.
  - After write 8: `full`=1, `data_count`=8.
  - A 9th write of 0x9 is dropped.
  - The next 8 reads return 0x1..0x8.
- Write 0xA5 into an empty FIFO at edge k: `dout`=0xA5 and `empty`=0 after edge k; pop at edge k+1 gives `empty`=1.
- Full FIFO, then `wr_en`=`rd_en`=1 for 20 cycles with an incrementing pattern: `data_count` stays 8, and output order is preserved across pointer wrap.
- Write packets of lengths 3 and 2 (EOP on words 3 and 5):
  - `pkt_count` is 0, 0, 1, 1, 2 after each write.
  - Reading 3 words drops `pkt_count` to 1.
  - `pkt_avail` falls only after the 5th read.
- Assert `reset` mid-stream with count=5 and `pkt_count`=2: all outputs take their reset values asynchronously, before the next `clk` edge.
- With `FALLTHROUGH_PKT_FIFO_ERR_CHK_EN` defined:
  - `rd_en` on empty sets `underflow`.
  - `wr_en` on full without a read sets `overflow`.
  - Both flags stay high until `reset`, and `data_count` is unaffected by either request.

Source files
------------

// File: rtl/fallthrough_pkt_fifo.sv
// fallthrough_pkt_fifo: first-word-fall-through FIFO with occupancy and complete-packet (EOP) counts.
// Define FALLTHROUGH_PKT_FIFO_ERR_CHK_EN to add sticky overflow/underflow flags.
module fallthrough_pkt_fifo #(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int NEARLY_FULL_THRESH  = 2**MAX_DEPTH_BITS - 1,
    parameter int NEARLY_EMPTY_THRESH = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_eop,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_eop,
    output logic                      full,
    output logic                      nearly_full,
    output logic                      empty,
    output logic                      nearly_empty,
    output logic [MAX_DEPTH_BITS:0]   data_count,
    output logic [MAX_DEPTH_BITS:0]   pkt_count,
    output logic                      pkt_avail
`ifdef FALLTHROUGH_PKT_FIFO_ERR_CHK_EN
    ,
    output logic                      overflow,
    output logic                      underflow
`endif
);

    localparam int DEPTH = 2**MAX_DEPTH_BITS;
    localparam int CW    = MAX_DEPTH_BITS + 1;
    localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
    localparam logic [CW-1:0] FULL_C    = CW'(DEPTH);
    localparam logic [CW-1:0] NF_THR_C  = CW'(NEARLY_FULL_THRESH);
    localparam logic [CW-1:0] NE_THR_C  = CW'(NEARLY_EMPTY_THRESH);

    logic [WIDTH:0]              mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               data_count_q, data_count_d;
    logic [CW-1:0]               pkt_count_q, pkt_count_d;
    logic                        wr_acc_s, rd_acc_s;
    logic                        pkt_inc_s, pkt_dec_s;

    // Head entry and status flags decode only registered state, so no input reaches an output.
    assign {dout_eop, dout} = mem_q[rd_ptr_q];
    assign empty        = (data_count_q == ZERO_C);
    assign full         = (data_count_q == FULL_C);
    assign nearly_full  = (data_count_q >= NF_THR_C);
    assign nearly_empty = (data_count_q <= NE_THR_C);
    assign data_count   = data_count_q;
    assign pkt_count    = pkt_count_q;
    assign pkt_avail    = (pkt_count_q != ZERO_C);

    // Acceptance and next-state for pointers and counters.
    always_comb begin
        wr_acc_s     = wr_en & (~full | rd_en);
        rd_acc_s     = rd_en & ~empty;
        pkt_inc_s    = wr_acc_s & din_eop;
        pkt_dec_s    = rd_acc_s & dout_eop;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        data_count_d = data_count_q;
        pkt_count_d  = pkt_count_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   data_count_d = data_count_q + 1'b1;
            2'b01:   data_count_d = data_count_q - 1'b1;
            default: data_count_d = data_count_q;
        endcase

        case ({pkt_inc_s, pkt_dec_s})
            2'b10:   pkt_count_d = pkt_count_q + 1'b1;
            2'b01:   pkt_count_d = pkt_count_q - 1'b1;
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= {MAX_DEPTH_BITS{1'b0}};
            rd_ptr_q     <= {MAX_DEPTH_BITS{1'b0}};
            data_count_q <= ZERO_C;
            pkt_count_q  <= ZERO_C;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            data_count_q <= data_count_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= {din_eop, din};
        end
    end

`ifdef FALLTHROUGH_PKT_FIFO_ERR_CHK_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error detection.
    always_comb begin
        overflow_d  = overflow_q | (wr_en & full & ~rd_en);
        underflow_d = underflow_q | (rd_en & empty);
    end

    // Sticky error registers, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifndef SYNTHESIS
    // Report each illegal request as it happens.
    always @(posedge clk) begin
        if (!reset && wr_en && full && !rd_en) begin
            $display("%0t: fallthrough_pkt_fifo overflow request", $time);
        end
        if (!reset && rd_en && empty) begin
            $display("%0t: fallthrough_pkt_fifo underflow request", $time);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_fallthrough_pkt_fifo.sv
// Scoreboard bench for fallthrough_pkt_fifo: stimulus pushes expected head words, a monitor pops on reads.
module tb_fallthrough_pkt_fifo;
    localparam int W     = 72;
    localparam int MDB   = 3;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   din;
    logic           din_eop;
    logic           wr_en;
    logic           rd_en;
    logic [W-1:0]   dout;
    logic           dout_eop;
    logic           full, nearly_full, empty, nearly_empty;
    logic [MDB:0]   data_count, pkt_count;
    logic           pkt_avail;
`ifdef FALLTHROUGH_PKT_FIFO_ERR_CHK_EN
    logic           overflow, underflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;
    logic [W:0] exp_q [$];
    logic [W:0] mon_exp;

    fallthrough_pkt_fifo #(
        .WIDTH(W), .MAX_DEPTH_BITS(MDB), .NEARLY_FULL_THRESH(7), .NEARLY_EMPTY_THRESH(1)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .din_eop(din_eop), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .dout_eop(dout_eop), .full(full), .nearly_full(nearly_full),
        .empty(empty), .nearly_empty(nearly_empty), .data_count(data_count),
        .pkt_count(pkt_count), .pkt_avail(pkt_avail)
`ifdef FALLTHROUGH_PKT_FIFO_ERR_CHK_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expected head word is queued when the write will be accepted.
    task automatic drive(input logic wr, input logic [W-1:0] d, input logic e, input logic rd);
        logic wa, ra;
        wa = wr && (m_cnt < DEPTH || rd);
        ra = rd && (m_cnt > 0);
        if (wa) exp_q.push_back({e, d});
        wr_en = wr; din = d; din_eop = e; rd_en = rd;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; din_eop = 1'b0;
        m_cnt = m_cnt + int'(wa) - int'(ra);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_empty"},   32'(empty),        32'd1);
        chk({tag, "_nempty"},  32'(nearly_empty), 32'd1);
        chk({tag, "_full"},    32'(full),         32'd0);
        chk({tag, "_nfull"},   32'(nearly_full),  32'd0);
        chk({tag, "_pavail"},  32'(pkt_avail),    32'd0);
        chk({tag, "_dcount"},  32'(data_count),   32'd0);
        chk({tag, "_pcount"},  32'(pkt_count),    32'd0);
`ifdef FALLTHROUGH_PKT_FIFO_ERR_CHK_EN
        chk({tag, "_ovf"},     32'(overflow),     32'd0);
        chk({tag, "_udf"},     32'(underflow),    32'd0);
`endif
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every accepted pop must present the oldest queued word.
    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_data: got %h, required no data (nothing queued)", {dout_eop, dout});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({dout_eop, dout} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got %h, required %h at %0t", {dout_eop, dout}, mon_exp, $time);
                end
            end
        end
    end

    initial begin
        int exp_pw [5];
        int exp_pr [5];
        exp_pw = '{0, 0, 1, 1, 2};
        exp_pr = '{2, 2, 1, 1, 0};
        reset = 1'b1; din = '0; din_eop = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        #3;
        check_reset("init");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill to full, boundary flags, dropped ninth write, drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0);
            if (i == 1) chk("nempty_at_1", 32'(nearly_empty), 32'd1);
            if (i == 2) chk("nempty_at_2", 32'(nearly_empty), 32'd0);
            if (i == 6) chk("nfull_at_6",  32'(nearly_full),  32'd0);
            if (i == 7) begin
                chk("nfull_at_7", 32'(nearly_full), 32'd1);
                chk("full_at_7",  32'(full),        32'd0);
            end
        end
        chk("full_at_8",   32'(full),       32'd1);
        chk("count_at_8",  32'(data_count), 32'd8);
        drive(1'b1, W'(9), 1'b0, 1'b0);
        chk("count_after_drop", 32'(data_count), 32'd8);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b0, 1'b1);
        chk("empty_after_drain", 32'(empty),      32'd1);
        chk("count_after_drain", 32'(data_count), 32'd0);

        // Read on empty is ignored; single word falls through in one cycle.
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("count_rd_empty", 32'(data_count), 32'd0);
        drive(1'b1, W'(8'hA5), 1'b0, 1'b0);
        chk("ft_dout",  dout[31:0],  32'h0000_00A5);
        chk("ft_empty", 32'(empty), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("ft_pop_empty", 32'(empty), 32'd1);

        // Full throughput across pointer wrap.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, W'(16'h0200 + i), 1'b0, 1'b1);
            chk("count_stream", 32'(data_count), 32'd8);
        end
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b0, 1'b1);
        chk("empty_after_stream", 32'(empty), 32'd1);

        // Packets of length 3 and 2.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'(16'h0300 + i), (i == 2 || i == 4), 1'b0);
            chk("pkt_wr", 32'(pkt_count), 32'(exp_pw[i]));
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            chk("pkt_rd",       32'(pkt_count), 32'(exp_pr[i]));
            chk("pkt_avail_rd", 32'(pkt_avail), 32'(i < 4));
        end

        // Asynchronous reset mid-stream with five words and two packets held.
        for (int i = 0; i < 5; i++) drive(1'b1, W'(16'h0400 + i), (i == 1 || i == 4), 1'b0);
        chk("mid_count", 32'(data_count), 32'd5);
        chk("mid_pkts",  32'(pkt_count),  32'd2);
        wr_en = 1'b1; rd_en = 1'b1; din = W'(16'h0BAD);
        #3;
        reset = 1'b1;
        #1;
        check_reset("async");
        wr_en = 1'b0; rd_en = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, W'(16'h03C3), 1'b1, 1'b0);
        chk("post_rst_count", 32'(data_count), 32'd1);
        chk("post_rst_pkts",  32'(pkt_count),  32'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("post_rst_empty", 32'(empty), 32'd1);

`ifdef FALLTHROUGH_PKT_FIFO_ERR_CHK_EN
        pulse_reset();
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("udf_set",   32'(underflow),  32'd1);
        chk("udf_ovf",   32'(overflow),   32'd0);
        chk("udf_count", 32'(data_count), 32'd0);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, W'(16'h0500 + i), 1'b0, 1'b0);
        drive(1'b1, W'(16'h0777), 1'b0, 1'b0);
        chk("ovf_set",   32'(overflow),   32'd1);
        chk("ovf_count", 32'(data_count), 32'd8);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_sticky", 32'(overflow),  32'd1);
        chk("udf_sticky", 32'(underflow), 32'd1);
        reset = 1'b1;
        #1;
        chk("ovf_clear", 32'(overflow),  32'd0);
        chk("udf_clear", 32'(underflow), 32'd0);
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
`endif

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
